// File: rtl/pll_drp_ctrl.sv
// PLL dynamic-reconfiguration controller.
// Applies a host-supplied list of masked read-modify-write operations to the
// PLLE2_ADV DRP port. The PLL is held in reset while the list runs. After the
// last entry the reset is released, the controller waits for lock, and it
// reports the outcome with a one-cycle done pulse and a sticky result code.
module pll_drp_ctrl #(
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int LOCK_BLANK   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_addr,
  input  logic [15:0] req_mask,
  input  logic [15:0] req_data,
  input  logic        req_last,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        pll_rst,
  input  logic        pll_locked,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err
);

  // One counter serves both the DRDY wait and the lock wait, so it is sized
  // for the longer of the two limits.
  localparam int CNT_MAX = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DRDY_LIM  = CW'(DRDY_TIMEOUT - 1);
  localparam logic [CW-1:0] LOCK_LIM  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] BLANK_LIM = CW'(LOCK_BLANK);

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_DRDY = 2'd1;
  localparam logic [1:0] ERR_LOCK = 2'd2;

  typedef enum logic [2:0] {
    IDLE, RD, RD_WAIT, WR, WR_WAIT, NEXT, LOCK_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   mask_q, mask_d;
  logic [15:0]   data_q, data_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lock_meta_q, lock_meta_d;
  logic          lock_sync_q, lock_sync_d;
  logic          req_ready_q, req_ready_d;
  logic          drp_den_q, drp_den_d;
  logic          drp_dwe_q, drp_dwe_d;
  logic [6:0]    drp_daddr_q, drp_daddr_d;
  logic [15:0]   drp_di_q, drp_di_d;
  logic          pll_rst_q, pll_rst_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [1:0]    err_q, err_d;
  logic          accept;

  // req_ready is registered, so acceptance uses the value the host sees.
  assign accept = req_valid & req_ready_q;

  // Next-state and registered-output computation. Outputs are decoded from
  // the next state so each registered output matches the state it belongs to.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    data_d      = data_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    drp_daddr_d = drp_daddr_q;
    drp_di_d    = drp_di_q;
    pll_rst_d   = pll_rst_q;
    err_d       = err_q;
    done_d      = 1'b0;
    lock_meta_d = pll_locked;
    lock_sync_d = lock_meta_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          drp_daddr_d = req_addr;
          mask_d      = req_mask;
          data_d      = req_data;
          last_d      = req_last;
          err_d       = ERR_OK;
          pll_rst_d   = 1'b1;
          state_d     = RD;
        end
      end
      RD: begin
        cnt_d   = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        // drdy is checked first so a same-cycle response beats the timeout.
        if (drp_drdy) begin
          drp_di_d = (drp_do & mask_q) | (data_q & ~mask_q);
          state_d  = WR;
        end else if (cnt_q == DRDY_LIM) begin
          pll_rst_d = 1'b0;
          done_d    = 1'b1;
          err_d     = ERR_DRDY;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WR: begin
        cnt_d   = '0;
        state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (drp_drdy) begin
          if (last_q) begin
            pll_rst_d = 1'b0;
            cnt_d     = '0;
            state_d   = LOCK_WAIT;
          end else begin
            state_d = NEXT;
          end
        end else if (cnt_q == DRDY_LIM) begin
          pll_rst_d = 1'b0;
          done_d    = 1'b1;
          err_d     = ERR_DRDY;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      NEXT: begin
        // No timeout here: the PLL stays in reset until the host finishes.
        if (accept) begin
          drp_daddr_d = req_addr;
          mask_d      = req_mask;
          data_d      = req_data;
          last_d      = req_last;
          state_d     = RD;
        end
      end
      LOCK_WAIT: begin
        // A lock left over from before the reset release is masked out by
        // the blanking window; a real lock wins over a same-cycle timeout.
        if ((cnt_q >= BLANK_LIM) && lock_sync_q) begin
          done_d  = 1'b1;
          err_d   = ERR_OK;
          state_d = IDLE;
        end else if (cnt_q == LOCK_LIM) begin
          done_d  = 1'b1;
          err_d   = ERR_LOCK;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE) || (state_d == NEXT);
    drp_den_d   = (state_d == RD) || (state_d == WR);
    drp_dwe_d   = (state_d == WR);
    busy_d      = (state_d != IDLE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      cnt_q       <= '0;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      req_ready_q <= 1'b1;
      drp_den_q   <= 1'b0;
      drp_dwe_q   <= 1'b0;
      drp_daddr_q <= '0;
      drp_di_q    <= '0;
      pll_rst_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= ERR_OK;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      data_q      <= data_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      lock_meta_q <= lock_meta_d;
      lock_sync_q <= lock_sync_d;
      req_ready_q <= req_ready_d;
      drp_den_q   <= drp_den_d;
      drp_dwe_q   <= drp_dwe_d;
      drp_daddr_q <= drp_daddr_d;
      drp_di_q    <= drp_di_d;
      pll_rst_q   <= pll_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign drp_den   = drp_den_q;
  assign drp_dwe   = drp_dwe_q;
  assign drp_daddr = drp_daddr_q;
  assign drp_di    = drp_di_q;
  assign pll_rst   = pll_rst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
